// File: rtl/arb_pkg.sv
// Shared arbiter definitions: grant-side state encoding and the index-width helper
// that the priority encoder and grant decoder both size their index buses with.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/grant_hold_timer.sv
// Saturating hold counter: load starts a grant at count 1, enable advances it,
// expired flags that the count has reached MAX_HOLD.
module grant_hold_timer #(
    parameter  int MAX_HOLD = 16,
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/grant_decoder.sv
// Converts an accepted winner index into a registered one-hot grant, held until the
// owner releases it or the hold timer runs out, with one dead cycle between grants.
//
// state   | meaning
// IDLE    | ready for a new index, no grant
// GRANT   | one-hot grant driven, waiting for release or hold expiry
// RECOVER | single dead cycle after a grant, input ignored
module grant_decoder
    import arb_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IW-1:0]    in_encoded,
    output logic             in_ready,
    input  logic [WIDTH-1:0] release_in,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_index,
    output logic             timeout,
    output logic             index_err
);

    localparam logic [IW:0] WIDTH_X = (IW + 1)'(WIDTH);

    state_t state;
    logic   in_range;
    logic   accept;
    logic   released;
    logic   expired;

    // Ready is held low while reset is asserted even though state is already IDLE.
    assign in_ready = rst_n && (state == IDLE);
    assign in_range = ({1'b0, in_encoded} < WIDTH_X);
    assign accept   = in_ready && in_valid && in_range;
    // Masking with the grant itself ignores release bits of non-granted requesters.
    assign released = |(release_in & grant);

    grant_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .enable  (state == GRANT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            timeout     <= 1'b0;
            index_err   <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            index_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_range) begin
                            state       <= GRANT;
                            grant       <= WIDTH'(1) << in_encoded;
                            grant_valid <= 1'b1;
                            grant_index <= in_encoded;
                        end else begin
                            index_err <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (released || expired) begin
                        state       <= RECOVER;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_index <= '0;
                        timeout     <= !released;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_decoder.sv
// Directed bench for grant_decoder: cycle table on a WIDTH=4 instance plus a short
// hand sequence on a WIDTH=3 instance for out-of-range indices.
module tb_grant_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4, MAX_HOLD=4 instance
    logic       rst_a = 1'b0;
    logic       valid_a = 1'b0;
    logic [1:0] enc_a = '0;
    logic [3:0] rel_a = '0;
    logic       ready_a;
    logic [3:0] grant_a;
    logic       gv_a;
    logic [1:0] gi_a;
    logic       to_a;
    logic       ie_a;

    // WIDTH=3, MAX_HOLD=4 instance
    logic       rst_b = 1'b0;
    logic       valid_b = 1'b0;
    logic [1:0] enc_b = '0;
    logic [2:0] rel_b = '0;
    logic       ready_b;
    logic [2:0] grant_b;
    logic       gv_b;
    logic [1:0] gi_b;
    logic       to_b;
    logic       ie_b;

    grant_decoder #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_a),
        .in_valid    (valid_a),
        .in_encoded  (enc_a),
        .in_ready    (ready_a),
        .release_in  (rel_a),
        .grant       (grant_a),
        .grant_valid (gv_a),
        .grant_index (gi_a),
        .timeout     (to_a),
        .index_err   (ie_a)
    );

    grant_decoder #(.WIDTH(3), .MAX_HOLD(4)) dut_b (
        .clk         (clk),
        .rst_n       (rst_b),
        .in_valid    (valid_b),
        .in_encoded  (enc_b),
        .in_ready    (ready_b),
        .release_in  (rel_b),
        .grant       (grant_b),
        .grant_valid (gv_b),
        .grant_index (gi_b),
        .timeout     (to_b),
        .index_err   (ie_b)
    );

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // one-hot invariant and grant_valid consistency on both instances every cycle
    always @(negedge clk) begin
        if (started) begin
            check("onehot_a", 32'($onehot0(grant_a) && (gv_a == |grant_a)), 32'd1);
            check("onehot_b", 32'($onehot0(grant_b) && (gv_b == |grant_b)), 32'd1);
        end
    end

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] enc;
        logic [3:0] rel;
        logic [3:0] g;
        logic       gv;
        logic [1:0] gi;
        logic       rdy;
        logic       to;
        logic       ie;
    } vec_t;

    function automatic vec_t mk(input int rst, input int v, input int enc, input int rel,
                                input int g, input int gi, input int rdy, input int to,
                                input int ie);
        vec_t r;
        r.rst = 1'(rst);
        r.v   = 1'(v);
        r.enc = 2'(enc);
        r.rel = 4'(rel);
        r.g   = 4'(g);
        r.gv  = (g != 0);
        r.gi  = 2'(gi);
        r.rdy = 1'(rdy);
        r.to  = 1'(to);
        r.ie  = 1'(ie);
        return r;
    endfunction

    vec_t vq[$];

    task automatic step_b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        vq.push_back(mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // index 2, released after two grant cycles
        vq.push_back(mk(1, 1, 2, 0,       4'b0100, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       4'b0100, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'b0100, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // index 1, never released: four grant cycles then timeout
        vq.push_back(mk(1, 1, 1, 0,       4'b0010, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 0, 0,   4'b0010, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // index 3 with a wrong-requester release: still times out
        vq.push_back(mk(1, 1, 3, 4'b0001, 4'b1000, 3, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 0, 4'b0001, 4'b1000, 3, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'b0001, 0,       0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // index 3 released in the 4th grant cycle: release beats timeout
        vq.push_back(mk(1, 1, 3, 0,       4'b1000, 3, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 0, 0,   4'b1000, 3, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'b1000, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // continuous in_valid, indices 0,1,2, each released after one grant cycle
        vq.push_back(mk(1, 1, 0, 0,       4'b0001, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 1, 4'b0001, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 1, 1, 0,       0,       0, 1, 0, 0));
        vq.push_back(mk(1, 1, 1, 0,       4'b0010, 1, 0, 0, 0));
        vq.push_back(mk(1, 1, 2, 4'b0010, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 1, 2, 0,       0,       0, 1, 0, 0));
        vq.push_back(mk(1, 1, 2, 0,       4'b0100, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'b0100, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        // reset on the edge that would otherwise time out
        vq.push_back(mk(1, 1, 3, 0,       4'b1000, 3, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 0, 0,   4'b1000, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));
        vq.push_back(mk(1, 1, 2, 0,       4'b0100, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'b0100, 0,       0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,       0,       0, 1, 0, 0));

        #1;
        foreach (vq[i]) begin
            rst_a   = vq[i].rst;
            valid_a = vq[i].v;
            enc_a   = vq[i].enc;
            rel_a   = vq[i].rel;
            @(posedge clk);
            #1;
            started = 1'b1;
            check($sformatf("row%0d grant", i),       32'(grant_a), 32'(vq[i].g));
            check($sformatf("row%0d grant_valid", i), 32'(gv_a),    32'(vq[i].gv));
            check($sformatf("row%0d grant_index", i), 32'(gi_a),    32'(vq[i].gi));
            check($sformatf("row%0d in_ready", i),    32'(ready_a), 32'(vq[i].rdy));
            check($sformatf("row%0d timeout", i),     32'(to_a),    32'(vq[i].to));
            check($sformatf("row%0d index_err", i),   32'(ie_a),    32'(vq[i].ie));
        end

        // WIDTH=3: out-of-range index 3 is rejected with a one-cycle index_err
        rst_b = 1'b0;
        step_b();
        check("b_reset_ready", 32'(ready_b), 32'd0);
        check("b_reset_grant", 32'(grant_b), 32'd0);
        rst_b = 1'b1;
        step_b();
        check("b_idle_ready", 32'(ready_b), 32'd1);
        valid_b = 1'b1;
        enc_b   = 2'd3;
        step_b();
        check("b_err_pulse", 32'(ie_b),    32'd1);
        check("b_err_grant", 32'(grant_b), 32'd0);
        check("b_err_gv",    32'(gv_b),    32'd0);
        check("b_err_ready", 32'(ready_b), 32'd1);
        valid_b = 1'b0;
        step_b();
        check("b_err_clear", 32'(ie_b),    32'd0);
        check("b_err_ready2", 32'(ready_b), 32'd1);
        valid_b = 1'b1;
        enc_b   = 2'd2;
        step_b();
        check("b_grant2",     32'(grant_b), 32'b100);
        check("b_grant2_idx", 32'(gi_b),    32'd2);
        check("b_grant2_err", 32'(ie_b),    32'd0);
        valid_b = 1'b0;
        rel_b   = 3'b100;
        step_b();
        check("b_release", 32'(grant_b), 32'd0);
        check("b_release_to", 32'(to_b), 32'd0);
        rel_b = '0;
        step_b();
        check("b_idle_again", 32'(ready_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
